// File: rtl/axis_sample_pacer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_sample_pacer_pkg
//  Description : Shared types and constants for the AXI4-Stream sample pacer.
//                Holds the FSM state encoding, underflow counter width and
//                the FIFO pointer width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package axis_sample_pacer_pkg;

  // Pacer FSM states; numeric values are what software sees on state_out
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } pacer_state_e;

  localparam int UF_CNT_WIDTH       = 16;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_FIFO_DEPTH = 16;

  // Pointers carry one extra wrap bit so full and empty differ only in the MSB
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEFAULT_PTR_WIDTH = $clog2(DEFAULT_FIFO_DEPTH) + 1;

endpackage
`default_nettype wire

// File: rtl/axis_sample_pacer_if.sv
`default_nettype none
// ============================================================================
//  Module      : axis_sample_pacer_if
//  Description : AXI4-Stream sample bus (TDATA/TVALID/TREADY/TLAST) between
//                the mm2s stage (master) and the sample pacer (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface axis_sample_pacer_if
  import axis_sample_pacer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface
`default_nettype wire

// File: rtl/axis_sample_pacer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : axis_pacer_fifo
//  Description : Synchronous FIFO with wrap-bit pointers, combinational read
//                port and registered-state full/empty/level flags.
//  Revision    : 1.0  initial release
// ============================================================================
module axis_pacer_fifo
  import axis_sample_pacer_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  wire logic                        ACLK,
  input  wire logic                        ARESETN,
  input  wire logic                        i_push,
  input  wire logic                        i_pop,
  input  wire logic [WIDTH-1:0]            i_din,
  output logic      [WIDTH-1:0]            o_dout,
  output logic                             o_full,
  output logic                             o_empty,
  output logic      [ptr_width(DEPTH)-1:0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Flags come only from registered pointers, so TREADY never sees TVALID
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_level   = r_wr_ptr - r_rd_ptr;
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage array is not reset; only the pointers define valid contents
  always_ff @(posedge ACLK) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end
  end

  // Pointer advance; async reset discards everything in flight
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_sample_pacer.sv
`default_nettype none
// ============================================================================
//  Module      : axis_sample_pacer
//  Description : Buffers an AXI4-Stream sample stream and releases one sample
//                per programmable tick to the DAC/modulator, with pre-fill,
//                TLAST passthrough and underflow accounting.
//  Revision    : 1.0  initial release
// ============================================================================
module axis_sample_pacer
  import axis_sample_pacer_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int PRIME_LEVEL = 8,
  parameter int DIV_WIDTH   = 16
) (
  input  wire logic                            ACLK,
  input  wire logic                            ARESETN,
  axis_sample_pacer_if.slave                   s_axis,
  input  wire logic                            cfg_enable,
  input  wire logic [DIV_WIDTH-1:0]            cfg_divider,
  output logic      [DATA_WIDTH-1:0]           sample_out,
  output logic                                 sample_valid,
  output logic                                 sample_last,
  output logic      [UF_CNT_WIDTH-1:0]         underflow_count,
  output logic      [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic      [1:0]                      state_out
);

  localparam int            PW          = ptr_width(FIFO_DEPTH);
  localparam logic [1:0]    C_ST_IDLE   = 2'(ST_IDLE);
  localparam logic [1:0]    C_ST_PRIME  = 2'(ST_PRIME);
  localparam logic [1:0]    C_ST_RUN    = 2'(ST_RUN);
  localparam logic [PW-1:0] C_PRIME_LVL = PW'(PRIME_LEVEL);

  logic [1:0]              r_state;
  logic [1:0]              w_state_nxt;
  logic [DIV_WIDTH-1:0]    r_div_cnt;
  logic [UF_CNT_WIDTH-1:0] r_uf_cnt;
  logic [DATA_WIDTH-1:0]   r_sample;
  logic                    r_sample_vld;
  logic                    r_sample_last;

  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic [DATA_WIDTH:0]     w_fifo_dout;
  logic [PW-1:0]           w_fifo_level;
  logic                    w_push;
  logic                    w_tick;
  logic                    w_pop;
  logic                    w_underflow;

  // Accept whenever there is room, regardless of state, so IDLE pre-fills
  assign s_axis.tready = !w_fifo_full;
  assign w_push        = s_axis.tvalid && !w_fifo_full;

  // The >= compare lets a lowered divider fire on the very next edge
  assign w_tick      = (r_state == C_ST_RUN) && (r_div_cnt >= cfg_divider);
  // Empty is registered, so a same-cycle push cannot rescue a tick
  assign w_pop       = w_tick && !w_fifo_empty;
  assign w_underflow = w_tick && w_fifo_empty;

  axis_pacer_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   ({s_axis.tlast, s_axis.tdata}),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (w_fifo_level)
  );

  // Next-state: disable always wins, PRIME waits for the fill threshold
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_ST_IDLE: begin
        if (cfg_enable) w_state_nxt = C_ST_PRIME;
      end
      C_ST_PRIME: begin
        if (!cfg_enable)                        w_state_nxt = C_ST_IDLE;
        else if (w_fifo_level >= C_PRIME_LVL)   w_state_nxt = C_ST_RUN;
      end
      C_ST_RUN: begin
        if (!cfg_enable) w_state_nxt = C_ST_IDLE;
      end
      default: w_state_nxt = C_ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= C_ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Divider: counts only while staying in RUN, reloads to 0 on each tick
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_div_cnt <= '0;
    end else if ((r_state != C_ST_RUN) || (w_state_nxt != C_ST_RUN) || w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);
    end
  end

  // Underflow counter: cleared on each new enable, saturates at all-ones
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_uf_cnt <= '0;
    end else if ((r_state == C_ST_IDLE) && cfg_enable) begin
      r_uf_cnt <= '0;
    end else if (w_underflow && (r_uf_cnt != {UF_CNT_WIDTH{1'b1}})) begin
      r_uf_cnt <= r_uf_cnt + UF_CNT_WIDTH'(1);
    end
  end

  // Output sample register: updates only on a successful pop, else holds
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_sample      <= '0;
      r_sample_last <= 1'b0;
      r_sample_vld  <= 1'b0;
    end else begin
      r_sample_vld <= w_pop;
      if (w_pop) begin
        r_sample      <= w_fifo_dout[DATA_WIDTH-1:0];
        r_sample_last <= w_fifo_dout[DATA_WIDTH];
      end
    end
  end

  assign sample_out      = r_sample;
  assign sample_valid    = r_sample_vld;
  assign sample_last     = r_sample_last;
  assign underflow_count = r_uf_cnt;
  assign fifo_level      = w_fifo_level;
  assign state_out       = r_state;

endmodule
`default_nettype wire

// File: doc/axis_sample_pacer.md
Name: axis_sample_pacer

Overview:
- AXI4-Stream slave that consumes the 32-bit sample stream produced by s_axis_mm2s and buffers it in a small FIFO.
- Releases one sample per programmable tick to the downstream DAC/modulator interface.
- Sits directly downstream of the mm2s stage in the digital radio datapath.
- Provides pre-fill (prime) control, TLAST passthrough, fill level and underflow accounting for software.

Parameters:
- DATA_WIDTH, 32, TDATA and sample width.
- FIFO_DEPTH, 16, FIFO entries; power of two, ≥4.
- PRIME_LEVEL, 8, FIFO level required before pacing starts; 1..FIFO_DEPTH.
- DIV_WIDTH, 16, width of the tick divider.

Ports:
- ACLK, in, 1, clock.
- ARESETN, in, 1, reset; asynchronous assert, active-low.
- S_AXIS_TDATA, in, DATA_WIDTH, sample data.
- S_AXIS_TVALID, in, 1, upstream data valid.
- S_AXIS_TREADY, out, 1, pacer can accept.
- S_AXIS_TLAST, in, 1, end of frame marker.
- cfg_enable, in, 1, run enable.
- cfg_divider, in, DIV_WIDTH, tick period minus 1.
- sample_out, out, DATA_WIDTH, current output sample.
- sample_valid, out, 1, one-cycle strobe when sample_out updates.
- sample_last, out, 1, TLAST of the current sample_out.
- underflow_count, out, 16, saturating count of missed ticks.
- fifo_level, out, $clog2(FIFO_DEPTH)+1, current occupancy.
- state_out, out, 2, current FSM state (IDLE=0, PRIME=1, RUN=2).

Behaviour:
- Reset (ARESETN low, async):
  - FIFO empty and pointers 0; state IDLE; divider counter 0.
  - sample_out=0, sample_valid=0, sample_last=0, underflow_count=0, fifo_level=0.
  - Outputs remain at reset values until the first rising ACLK edge after release.
  - Reset mid-transfer discards all FIFO contents and any in-flight beat.
- Input handshake:
  - S_AXIS_TREADY = !full. It is independent of state, so the FIFO pre-fills while IDLE.
  - A beat is accepted on a rising edge where TVALID && TREADY; {TLAST,TDATA} is pushed.
  - TREADY is combinational from registered FIFO state only (no TVALID→TREADY path).
- FSM:
  - IDLE:
    - Divider counter held at 0; no ticks.
    - cfg_enable=1 → PRIME; on that transition underflow_count clears to 0.
  - PRIME:
    - Counter held at 0; no ticks.
    - fifo_level ≥ PRIME_LEVEL → RUN.
    - cfg_enable=0 → IDLE (takes priority).
  - RUN:
    - Counter increments each cycle. Tick when counter ≥ cfg_divider, and counter reloads to 0 that cycle.
    - cfg_divider=0 gives a tick every cycle.
    - A lowered cfg_divider takes effect immediately via the ≥ compare.
    - cfg_enable=0 → IDLE. FIFO contents are retained; sample_out holds its value.
- Tick action (RUN only):
  - FIFO non-empty: pop. sample_out<=data, sample_last<=last, sample_valid=1 for exactly that following cycle.
  - FIFO empty: no pop; sample_out and sample_last hold; sample_valid=0; underflow_count increments, saturating at 16'hFFFF.
  - RUN is not left on underflow.
- Simultaneous events:
  - Push and pop in the same cycle: fifo_level unchanged.
  - Tick while empty with a push in the same cycle: counts as underflow (no bypass). The pushed beat is available on the next tick.
  - Full with a tick: pop frees a slot; TREADY rises the following cycle.
- Latency:
  - A beat accepted at edge N is poppable by a tick at edge N+1 or later.
  - sample_out changes at the tick edge.
- Wrap-around: FIFO pointers are $clog2(FIFO_DEPTH)+1 bits; full/empty are determined by the MSB compare.

Decomposition:
- Package axis_sample_pacer_pkg:
  - state enum {IDLE, PRIME, RUN}.
  - UF_CNT_WIDTH=16.
  - Localparams for pointer width.
- Sub-module axis_pacer_fifo: synchronous FIFO, width DATA_WIDTH+1.
  - Ports: push, pop, din, dout, full, empty, level.
  - Same ACLK/ARESETN.
- Top level holds the FSM, divider, output registers and underflow counter.

Test Plan:
- Prime:
  - Stimulus: reset, cfg_enable=1, cfg_divider=3, push 0x01..0x08 back-to-back.
  - Response: state reaches RUN the cycle after fifo_level=8. sample_valid pulses every 4 cycles with sample_out 0x01,0x02,…,0x08 in order.
- Underflow:
  - Stimulus: continuing from Prime, after 8 samples push nothing for 3 ticks.
  - Response: sample_out holds 0x08, sample_valid stays 0, underflow_count=3.
- Full/backpressure:
  - Stimulus: cfg_enable=0, push 20 beats with TVALID held high.
  - Response: 16 accepted, TREADY=0 with fifo_level=16. Enable with cfg_divider=0: TREADY returns 1 the cycle after the first pop; data order is preserved.
- TLAST:
  - Stimulus: push 4 beats with TLAST on the 4th (0xDEAD0011).
  - Response: sample_last=1 only while sample_out=0xDEAD0011.
- Divider change:
  - Stimulus: in RUN, counter at 5 with cfg_divider=9, change cfg_divider to 2.
  - Response: tick on the next edge, then every 3 cycles.
- Async reset mid-run:
  - Stimulus: assert ARESETN low between clock edges with fifo_level=5.
  - Response: all outputs, fifo_level and underflow_count are 0 immediately, without waiting for a clock edge. TREADY=1 after release.
